// File: rtl/eep_spi_responder.sv
// SPI mode-0 responder modelling the calibration EEPROM: 16-bit frames {op, addr, data}
// decoded against a byte array, read data returned on MISO during the following frame.
module eep_spi_responder #(
    parameter int         ADDR_W      = 6,
    parameter logic [7:0] INIT_VAL    = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_oe,
    output logic       frame_done,
    output logic [1:0] last_cmd
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // SYNC_STAGES must be at least 2 for the slice below to be legal.
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   ss_prev_q, ss_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  bit_cnt_inc;
    logic [15:0] rx_shift_q, rx_shift_d;
    logic [15:0] tx_shift_q, tx_shift_d;
    logic [7:0]  rd_byte_q, rd_byte_d;
    logic [1:0]  last_cmd_q, last_cmd_d;
    logic        frame_done_q, frame_done_d;

    logic              ss_s, sclk_s, mosi_s;
    logic              ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    // Array is deliberately outside the reset domain: contents survive rst.
    logic [7:0] mem_q [DEPTH] = '{default: INIT_VAL};

    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        ss_prev_d   = ss_s;
        sclk_prev_d = sclk_s;
        ss_fall     = ss_prev_q & ~ss_s;
        ss_rise     = ~ss_prev_q & ss_s;
        sclk_rise   = ~sclk_prev_q & sclk_s;
        sclk_fall   = sclk_prev_q & ~sclk_s;
    end

    assign mem_addr  = rx_shift_q[8 +: ADDR_W];
    assign mem_wdata = rx_shift_q[7:0];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rd_byte_d    = rd_byte_q;
        last_cmd_d   = last_cmd_q;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;
        bit_cnt_inc  = bit_cnt_q + 5'd1;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_shift_d = {8'h00, rd_byte_q};
                    bit_cnt_d  = 5'd0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[14:0], mosi_s};
                        bit_cnt_d  = bit_cnt_inc;
                        if (bit_cnt_inc == 5'd16) begin
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_shift_d = {tx_shift_q[14:0], 1'b0};
                    end
                end
            end
            DONE: begin
                // frame_done_q is high for exactly the first DONE cycle: decode once here.
                if (frame_done_q) begin
                    last_cmd_d = rx_shift_q[15:14];
                    case (rx_shift_q[15:14])
                        2'b01:   mem_we = 1'b1;
                        2'b00:   rd_byte_d = mem_q[mem_addr];
                        default: ;
                    endcase
                end
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q    <= '1;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            ss_prev_q    <= 1'b1;
            sclk_prev_q  <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 5'd0;
            rx_shift_q   <= 16'h0000;
            tx_shift_q   <= 16'h0000;
            rd_byte_q    <= 8'h00;
            last_cmd_q   <= 2'b00;
            frame_done_q <= 1'b0;
        end else begin
            ss_sync_q    <= ss_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            ss_prev_q    <= ss_prev_d;
            sclk_prev_q  <= sclk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rd_byte_q    <= rd_byte_d;
            last_cmd_q   <= last_cmd_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign MISO       = tx_shift_q[15];
    assign MISO_oe    = ~ss_s;
    assign frame_done = frame_done_q;
    assign last_cmd   = last_cmd_q;

endmodule

// File: tb/tb_eep_spi_responder.sv
// Directed bench for eep_spi_responder: drives mode-0 SPI frames and scores the MISO
// response words, frame_done pulse counts and last_cmd against hand-computed values.
module tb_eep_spi_responder;
    logic       clk;
    logic       rst;
    logic       SS_n;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       MISO_oe;
    logic       frame_done;
    logic [1:0] last_cmd;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    logic [15:0] exp_q[$];

    eep_spi_responder dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .MISO_oe    (MISO_oe),
        .frame_done (frame_done),
        .last_cmd   (last_cmd)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        wait_clks(n);
        rst = 1'b0;
    endtask

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver: one SS_n-low window with n_sclk SCLK pulses; bits past 16 are driven as 1
    task automatic spi_frame(input logic [15:0] word, input int n_sclk, output logic [15:0] resp);
        resp = 16'h0000;
        SS_n = 1'b0;
        wait_clks(8);
        for (int i = 0; i < n_sclk; i++) begin
            MOSI = (i < 16) ? word[15-i] : 1'b1;
            wait_clks(4);
            if (i < 16) resp = {resp[14:0], MISO};
            SCLK = 1'b1;
            wait_clks(8);
            SCLK = 1'b0;
            wait_clks(4);
        end
        wait_clks(8);
        SS_n = 1'b1;
        MOSI = 1'b0;
        wait_clks(12);
    endtask

    task automatic xfer(input string tag, input logic [15:0] word, input int n_sclk,
                        input logic [15:0] exp_resp);
        logic [15:0] resp;
        exp_q.push_back(exp_resp);
        spi_frame(word, n_sclk, resp);
        check_val(tag, resp, exp_q.pop_front());
    endtask

    initial begin
        int fd0;
        logic [15:0] dummy_resp;
        rst  = 1'b0;
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;

        rst = 1'b1;
        wait_clks(3);
        check_val("rst_miso", {15'd0, MISO}, 16'h0000);
        check_val("rst_oe", {15'd0, MISO_oe}, 16'h0000);
        check_val("rst_frame_done", {15'd0, frame_done}, 16'h0000);
        check_val("rst_last_cmd", {14'd0, last_cmd}, 16'h0000);
        wait_clks(2);
        rst = 1'b0;
        wait_clks(4);

        // 1: write 0x5C to 0x0A, read back through a dummy frame
        fd0 = fd_cnt;
        xfer("t1_wr_resp", 16'h4A5C, 16, 16'h0000);
        check_val("t1_fd_count", 16'(fd_cnt - fd0), 16'd1);
        check_val("t1_last_cmd", {14'd0, last_cmd}, 16'h0001);
        xfer("t1_rd_resp", 16'h0A00, 16, 16'h0000);
        xfer("t1_dummy_resp", 16'hC000, 16, 16'h005C);

        // 2: untouched address, MISO_oe tracking, select without clocks
        xfer("t2_rd_resp", 16'h3F00, 16, 16'h005C);
        xfer("t2_dummy_resp", 16'hC000, 16, 16'h0000);
        check_val("t2_oe_idle", {15'd0, MISO_oe}, 16'h0000);
        fd0 = fd_cnt;
        SS_n = 1'b0;
        wait_clks(8);
        check_val("t2_oe_selected", {15'd0, MISO_oe}, 16'h0001);
        SS_n = 1'b1;
        wait_clks(8);
        check_val("t2_oe_deselected", {15'd0, MISO_oe}, 16'h0000);
        check_val("t2_noclk_fd", 16'(fd_cnt - fd0), 16'd0);

        // 3: abort a write after 9 clocks
        fd0 = fd_cnt;
        spi_frame(16'h4133, 9, dummy_resp);
        check_val("t3_abort_fd", 16'(fd_cnt - fd0), 16'd0);
        xfer("t3_rd_resp", 16'h0100, 16, 16'h0000);
        xfer("t3_dummy_resp", 16'hC000, 16, 16'h0000);

        // 4: 20 clocks in one frame, extra bits ignored
        fd0 = fd_cnt;
        xfer("t4_wr_resp", 16'h4211, 20, 16'h0000);
        check_val("t4_fd_count", 16'(fd_cnt - fd0), 16'd1);
        xfer("t4_rd_resp", 16'h0200, 16, 16'h0000);
        xfer("t4_dummy_resp", 16'hC000, 16, 16'h0011);

        // 5: array retained across reset, rd_byte cleared
        xfer("t5_wr_resp", 16'h45A7, 16, 16'h0011);
        do_reset(3);
        wait_clks(1);
        check_val("t5_rst_last_cmd", {14'd0, last_cmd}, 16'h0000);
        check_val("t5_rst_oe", {15'd0, MISO_oe}, 16'h0000);
        wait_clks(4);
        xfer("t5_post_rst_resp", 16'hC000, 16, 16'h0000);
        xfer("t5_rd_resp", 16'h0500, 16, 16'h0000);
        xfer("t5_dummy_resp", 16'hC000, 16, 16'h00A7);

        // 6: op 11 no-op leaves array and rd_byte alone
        fd0 = fd_cnt;
        xfer("t6_nop_resp", 16'hC0FF, 16, 16'h00A7);
        check_val("t6_fd_count", 16'(fd_cnt - fd0), 16'd1);
        check_val("t6_last_cmd", {14'd0, last_cmd}, 16'h0003);
        xfer("t6_nop2_resp", 16'hC0FF, 16, 16'h00A7);
        xfer("t6_rd0_resp", 16'h0000, 16, 16'h00A7);
        xfer("t6_dummy_resp", 16'h8000, 16, 16'h0000);
        check_val("t6_last_cmd_10", {14'd0, last_cmd}, 16'h0002);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
